cdc_handshake_tx: RTL and testbench

//  Source end of a 4-phase req/ack bundled-data CDC link; counterpart to the destination-side synchronizer.

---
 rtl/cdc_hs_pkg.sv | 21 ++
 rtl/cdc_ack_sync.sv | 29 ++
 rtl/cdc_handshake_tx.sv | 139 +++++++++++++
 tb/tb_cdc_handshake_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_hs_pkg
// Purpose  : Shared types and helpers for the 4-phase req/ack CDC source end.
// Revision : 1.0
// ============================================================================
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    // Counter width able to hold n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_ack_sync.sv
`default_nettype none
// ============================================================================
// Module   : cdc_ack_sync
// Purpose  : Multi-flop synchronizer bringing the remote ack into clk domain.
// Revision : 1.0
// ============================================================================
module cdc_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ack_async,
    output logic o_ack_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_ack_async};
        end
    end

    assign o_ack_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Source end of a 4-phase req/ack bundled-data CDC link with
//            synchronized ack, completion pulse and stall timeout.
// Revision : 1.0
// ============================================================================
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               SYNC_STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             err_clr
);

    localparam int                 c_cnt_w    = cnt_width(TIMEOUT_CYCLES);
    localparam bit                 c_to_en    = (TIMEOUT_CYCLES != 0);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_to_en ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

    hs_state_t          r_state;
    hs_state_t          w_state_nxt;
    logic               r_req;
    logic               w_req_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_error;
    logic               w_error_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   r_data;
    logic               w_ack_s;
    logic               w_accept;
    logic               w_timeout;

    cdc_ack_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk         (clk),
        .reset       (reset),
        .i_ack_async (ack_in),
        .o_ack_sync  (w_ack_s)
    );

    // A stale ack still high in IDLE blocks new words until the partner releases.
    assign in_ready  = (r_state == IDLE) && !w_ack_s && !r_error;
    assign w_accept  = in_valid && in_ready;
    assign w_timeout = c_to_en && (r_state != IDLE) && (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_done_nxt  = 1'b0;
        w_error_nxt = r_error;
        w_cnt_nxt   = '0;

        if (err_clr) begin
            w_error_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                    w_req_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = RELEASE;
                    w_req_nxt   = 1'b0;
                end
            end
            RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase

        // An expiring timeout overrides both normal progress and err_clr.
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
            w_error_nxt = 1'b1;
        end

        if ((w_state_nxt == r_state) && (r_state != IDLE)) begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_data  <= RESET_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_data <= in_data;
            end
        end
    end

    assign req_out  = r_req;
    assign data_out = r_data;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Purpose  : Self-checking bench for cdc_handshake_tx with a remote-receiver
//            model and a transaction-level reference of the link.
// Revision : 1.0
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int          W  = 32;
    localparam int          SS = 2;
    localparam int          TO = 16;
    localparam logic [31:0] RV = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        req_out;
    logic [31:0] data_out;
    logic        ack_in = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Remote receiver: either echoes req_out rx_n cycles late, or holds ack_man.
    bit          rx_mode = 1'b0;
    bit          ack_man = 1'b0;
    int          rx_n = 3;
    logic [15:0] req_hist = '0;

    // Reference: phase flags, age in phase, and ack pipeline as a queue.
    bit          m_busy = 1'b0;
    bit          m_req = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_data = RV;
    int          m_age = 0;
    bit          ack_q[$] = '{1'b0, 1'b0};

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        e_req;
        logic        e_busy;
        logic        e_rdy;
        logic        e_done;
    } vec_t;
    vec_t tbl[9];

    cdc_handshake_tx #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .RESET_VALUE    (RV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        req_hist = {req_hist[14:0], req_out};
        ack_in   = rx_mode ? req_hist[rx_n] : ack_man;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ack_s;
        bit to;
        ack_s = ack_q[$];
        if (reset) begin
            m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_data = RV;   m_age = 0;
            ack_q  = {};
            repeat (SS) ack_q.push_back(1'b0);
        end else begin
            to     = m_busy && (m_age == TO - 1);
            m_done = 1'b0;
            if (to) begin
                m_busy = 1'b0; m_req = 1'b0; m_err = 1'b1; m_age = 0;
            end else if (!m_busy) begin
                if (in_valid && !ack_s && !m_err) begin
                    m_busy = 1'b1; m_req = 1'b1; m_data = in_data; m_age = 0;
                end
            end else if (m_req ? ack_s : !ack_s) begin
                m_done = !m_req; m_busy = m_req; m_req = 1'b0; m_age = 0;
            end else begin
                m_age++;
            end
            if (err_clr && !to) m_err = 1'b0;
            ack_q.push_front(ack_in);
            void'(ack_q.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("m_req_out",  req_out,  m_req);
        chk("m_data_out", data_out, m_data);
        chk("m_in_ready", in_ready, !m_busy && !ack_q[$] && !m_err);
        chk("m_busy",     busy,     m_busy);
        chk("m_done",     done,     m_done);
        chk("m_error",    error,    m_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen1;
        bit got;
        int ndone;

        tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_req", req_out, 1'b0);
        chk("rst_data", data_out, RV);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        reset = 1'b0;

        // Single DEADBEEF handshake with hand-timed ack edges
        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            ack_man  = tbl[i].a;
            tick();
            chk("t2_req",   req_out,  tbl[i].e_req);
            chk("t2_busy",  busy,     tbl[i].e_busy);
            chk("t2_ready", in_ready, tbl[i].e_rdy);
            chk("t2_done",  done,     tbl[i].e_done);
            chk("t2_data",  data_out, 32'hDEADBEEF);
        end

        // Back-to-back words with in_valid held
        rx_mode = 1'b1; rx_n = 3;
        in_valid = 1'b1; in_data = 32'd1;
        tick();
        chk("t3_word1", data_out, 32'd1);
        in_data = 32'd2; seen1 = 1'b0; ndone = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!seen1) begin
                chk("t3_hold1", data_out, 32'd1);
                if (done) begin seen1 = 1'b1; ndone++; end
            end else if (in_valid) begin
                chk("t3_acc2_busy", busy, 1'b1);
                chk("t3_word2", data_out, 32'd2);
                in_valid = 1'b0;
            end else if (done) begin
                ndone++;
            end
        end
        chk("t3_done_count", ndone, 2);

        // Timeout with ack stuck low; err_clr held across the expiring edge
        rx_mode = 1'b0; ack_man = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_4444;
        tick();
        in_valid = 1'b0; err_clr = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("t4_req_hold", req_out, 1'b1);
            chk("t4_err_low", error, 1'b0);
        end
        tick();
        chk("t4_req_drop", req_out, 1'b0);
        chk("t4_err_set", error, 1'b1);
        chk("t4_ready_blk", in_ready, 1'b0);
        chk("t4_no_done", done, 1'b0);
        err_clr = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("t4_err_sticky", error, 1'b1);
            chk("t4_no_accept", busy, 1'b0);
        end
        in_valid = 1'b0; err_clr = 1'b1;
        tick();
        chk("t4_err_clr", error, 1'b0);
        chk("t4_ready_back", in_ready, 1'b1);
        err_clr = 1'b0;

        // Reset while in REQ with ack high
        in_valid = 1'b1; in_data = 32'h0000_5555;
        tick();
        in_valid = 1'b0; ack_man = 1'b1;
        tick(); tick();
        chk("t5_in_req", req_out, 1'b1);
        reset = 1'b1;
        tick();
        chk("t5_req", req_out, 1'b0);
        chk("t5_data", data_out, RV);
        chk("t5_busy", busy, 1'b0);
        reset = 1'b0;
        tick(); tick();
        chk("t5_ready_blk", in_ready, 1'b0);
        ack_man = 1'b0;
        tick(); tick();
        chk("t5_ready_back", in_ready, 1'b1);

        // Stale ack in IDLE blocks acceptance without raising error
        ack_man = 1'b1;
        tick(); tick();
        in_valid = 1'b1; in_data = 32'h0000_6666;
        repeat (10) begin
            tick();
            chk("t6_busy", busy, 1'b0);
            chk("t6_req", req_out, 1'b0);
            chk("t6_err", error, 1'b0);
        end
        ack_man = 1'b0;
        tick(); chk("t6_wait1", busy, 1'b0);
        tick(); chk("t6_wait2", busy, 1'b0);
        tick(); chk("t6_accept", busy, 1'b1);
        chk("t6_data", data_out, 32'h0000_6666);
        in_valid = 1'b0; rx_mode = 1'b1; rx_n = 2; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin got = 1'b1; break; end
        end
        chk("t6_complete", got, 1'b1);

        // Randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            if (c % 97 == 0) begin
                rx_mode = ($urandom_range(0, 3) != 0);
                ack_man = 1'($urandom_range(0, 1));
            end
            if (!m_busy && $urandom_range(0, 7) == 0) rx_n = $urandom_range(1, 6);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            err_clr  = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
